// File: rtl/tmds_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : tmds_decoder_if
// Brief    : Raw deserialized word in, decoded symbol and lock status out.
// Revision : 1.0
// ============================================================================
interface tmds_decoder_if;
    logic [9:0] i_raw;
    logic       o_de;
    logic [1:0] o_ctrl;
    logic [7:0] o_data;
    logic       o_locked;
    logic [3:0] o_offset;
    logic       o_err;

    modport master (
        output i_raw,
        input  o_de, o_ctrl, o_data, o_locked, o_offset, o_err
    );

    modport slave (
        input  i_raw,
        output o_de, o_ctrl, o_data, o_locked, o_offset, o_err
    );
endinterface
`default_nettype wire

// File: rtl/tmds_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tmds_decoder
// Brief    : TMDS channel receiver: word alignment by control-token hunt,
//            then decode of each aligned symbol to DE / control / pixel data.
// Revision : 1.0
// ============================================================================
module tmds_decoder #(
    parameter int LOCK_TOKENS = 16,
    parameter int TIMEOUT     = 4096
) (
    input  wire           i_clk,
    input  wire           i_rstn,
    tmds_decoder_if.slave bus
);
    localparam int c_GAP_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_TOK_W = $clog2(LOCK_TOKENS);
    localparam logic [c_GAP_W-1:0] c_GAP_MAX  = c_GAP_W'(TIMEOUT - 1);
    localparam logic [c_TOK_W-1:0] c_TOK_LAST = c_TOK_W'(LOCK_TOKENS - 1);
    localparam logic [c_TOK_W-1:0] c_TOK_ONE  = c_TOK_W'(1);

    localparam logic [1:0] c_ST_SEARCH = 2'd0;
    localparam logic [1:0] c_ST_VERIFY = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;

    logic [9:0]         r_new, r_old;
    logic [1:0]         r_state, w_state_nxt;
    logic [c_GAP_W-1:0] r_gap, w_gap_nxt;
    logic [c_TOK_W-1:0] r_tok, w_tok_nxt;
    logic [3:0]         r_offset, w_offset_nxt, w_offset_inc;
    logic               r_de, w_de_nxt;
    logic [1:0]         r_ctrl, w_ctrl_nxt;
    logic [7:0]         r_data, w_data_nxt;
    logic               r_err, w_err_nxt;

    logic [19:0]        w_stream;
    logic [9:0]         w_sym;
    logic               w_is_tok;
    logic [1:0]         w_tok_ctrl;
    logic [7:0]         w_q, w_d;
    logic [6:0]         w_x;

    // r_old holds the earlier word, so a symbol straddling two words reads
    // upward from bit r_offset of the concatenation.
    assign w_stream = {r_new, r_old};
    assign w_sym    = 10'(w_stream >> r_offset);

    always_comb begin
        w_is_tok   = 1'b1;
        w_tok_ctrl = 2'b00;
        case (w_sym)
            10'b1101010100: w_tok_ctrl = 2'b00;
            10'b0010101011: w_tok_ctrl = 2'b01;
            10'b0101010100: w_tok_ctrl = 2'b10;
            10'b1010101011: w_tok_ctrl = 2'b11;
            default:        w_is_tok   = 1'b0;
        endcase
    end

    assign w_q = w_sym[9] ? ~w_sym[7:0] : w_sym[7:0];
    assign w_x = w_q[7:1] ^ w_q[6:0];
    assign w_d = {(w_sym[8] ? w_x : ~w_x), w_q[0]};

    assign w_offset_inc = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_gap_nxt    = r_gap;
        w_tok_nxt    = r_tok;
        w_offset_nxt = r_offset;
        w_err_nxt    = 1'b0;
        case (r_state)
            c_ST_SEARCH: begin
                // A token at the current offset takes priority over a slip.
                if (w_is_tok) begin
                    w_state_nxt = c_ST_VERIFY;
                    w_tok_nxt   = c_TOK_ONE;
                    w_gap_nxt   = '0;
                end else if (r_gap == c_GAP_MAX) begin
                    w_offset_nxt = w_offset_inc;
                    w_gap_nxt    = '0;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            c_ST_VERIFY: begin
                if (w_is_tok) begin
                    if (r_tok == c_TOK_LAST) begin
                        w_state_nxt = c_ST_LOCKED;
                        w_gap_nxt   = '0;
                        w_tok_nxt   = '0;
                    end else begin
                        w_tok_nxt = r_tok + 1'b1;
                    end
                end else begin
                    w_state_nxt  = c_ST_SEARCH;
                    w_offset_nxt = w_offset_inc;
                    w_gap_nxt    = '0;
                    w_tok_nxt    = '0;
                end
            end
            c_ST_LOCKED: begin
                if (w_is_tok) begin
                    w_gap_nxt = '0;
                end else if (r_gap == c_GAP_MAX) begin
                    w_state_nxt = c_ST_SEARCH;
                    w_gap_nxt   = '0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_SEARCH;
                w_gap_nxt   = '0;
                w_tok_nxt   = '0;
            end
        endcase

        // Output follows the next state so the lock-completing symbol is shown.
        w_de_nxt   = 1'b0;
        w_ctrl_nxt = 2'b00;
        w_data_nxt = 8'h00;
        if (w_state_nxt == c_ST_LOCKED) begin
            if (w_is_tok) begin
                w_ctrl_nxt = w_tok_ctrl;
            end else begin
                w_de_nxt   = 1'b1;
                w_data_nxt = w_d;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_new    <= '0;
            r_old    <= '0;
            r_state  <= c_ST_SEARCH;
            r_gap    <= '0;
            r_tok    <= '0;
            r_offset <= '0;
            r_de     <= 1'b0;
            r_ctrl   <= 2'b00;
            r_data   <= 8'h00;
            r_err    <= 1'b0;
        end else begin
            r_new    <= bus.i_raw;
            r_old    <= r_new;
            r_state  <= w_state_nxt;
            r_gap    <= w_gap_nxt;
            r_tok    <= w_tok_nxt;
            r_offset <= w_offset_nxt;
            r_de     <= w_de_nxt;
            r_ctrl   <= w_ctrl_nxt;
            r_data   <= w_data_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign bus.o_de     = r_de;
    assign bus.o_ctrl   = r_ctrl;
    assign bus.o_data   = r_data;
    assign bus.o_locked = (r_state == c_ST_LOCKED);
    assign bus.o_offset = r_offset;
    assign bus.o_err    = r_err;
endmodule
`default_nettype wire

// File: tb/tb_tmds_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmds_decoder
// Brief    : Directed bench for tmds_decoder with a DVI encoder model and
//            a bit-slip serializer model.
// Revision : 1.0
// ============================================================================
module tb_tmds_decoder;
    localparam logic [9:0] c_TOK_SYM [4] = '{10'b1101010100, 10'b0010101011,
                                             10'b0101010100, 10'b1010101011};

    logic clk = 1'b0;
    logic rstn;
    tmds_decoder_if bus();

    tmds_decoder #(.LOCK_TOKENS(4), .TIMEOUT(64)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    int          slip    = 0;
    int          enc_cnt = 0;
    logic [9:0]  prev_sym = '0;
    logic [10:0] hist [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // DVI 8b/10b encoder with running disparity.
    task automatic encode(input logic [7:0] d, output logic [9:0] w);
        logic [8:0] qm;
        int n1d, n1q, n0q;
        n1d   = $countones(d);
        qm[0] = d[0];
        if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (enc_cnt == 0 || n1q == n0q) begin
            w = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            enc_cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
            w = {1'b1, qm[8], ~qm[7:0]};
            enc_cnt += 2 * int'(qm[8]) + n0q - n1q;
        end else begin
            w = {1'b0, qm[8], qm[7:0]};
            enc_cnt += -2 * int'(!qm[8]) + n1q - n0q;
        end
    endtask

    // Drive one word whose symbol starts at bit `slip`, then sample #1 after the edge.
    task automatic send_word(input logic [9:0] sym, input logic [10:0] expv);
        logic [19:0] pair;
        pair      = {sym, prev_sym};
        bus.i_raw = 10'(pair >> (10 - slip));
        prev_sym  = sym;
        hist[2]   = hist[1];
        hist[1]   = hist[0];
        hist[0]   = expv;
        @(posedge clk);
        #1;
    endtask

    task automatic send_tok(input logic [1:0] c);
        enc_cnt = 0;
        send_word(c_TOK_SYM[c], {1'b0, c, 8'h00});
    endtask

    task automatic send_data(input logic [7:0] d);
        logic [9:0] w;
        encode(d, w);
        send_word(w, {1'b1, 2'b00, d});
    endtask

    task automatic check_out(input string tag);
        chk(tag, {21'd0, bus.o_de, bus.o_ctrl, bus.o_data}, {21'd0, hist[2]});
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        prev_sym = '0;
        enc_cnt  = 0;
        repeat (2) send_word(10'h000, 11'h000);
        rstn = 1'b1;
    endtask

    task automatic lock_with_tokens(input int limit);
        for (int i = 0; i < limit && !bus.o_locked; i++) send_tok(2'd0);
    endtask

    initial begin
        int last_off, dwell, dwell_bad, adv_bad, err_cnt, lock_bad, seen_lock;
        bus.i_raw = '0;
        for (int i = 0; i < 3; i++) hist[i] = '0;

        // Reset state and aligned lock
        slip = 0;
        do_reset();
        chk("rst_locked", bus.o_locked, 0);
        chk("rst_offset", bus.o_offset, 0);
        chk("rst_err", bus.o_err, 0);
        chk("rst_out", {bus.o_de, bus.o_ctrl, bus.o_data}, 0);
        for (int i = 0; i < 20; i++) begin
            send_tok(2'd0);
            if (i == 4) chk("t1_prelock", bus.o_locked, 0);
            if (i == 5) begin
                chk("t1_lock", bus.o_locked, 1);
                chk("t1_offset", bus.o_offset, 0);
            end
            if (i >= 5) check_out("t1_blank");
        end
        for (int c = 0; c < 8; c++) begin
            for (int j = 0; j < 32; j++) begin
                send_data(8'(c * 32 + j));
                check_out("t1_data");
            end
            for (int j = 0; j < 4; j++) begin
                send_tok(2'd0);
                check_out("t1_blank2");
            end
        end

        // Misaligned lock at slip 7, then control decode
        slip = 7;
        do_reset();
        last_off = 0; dwell = 0; dwell_bad = 0; adv_bad = 0;
        for (int i = 0; i < 800 && !bus.o_locked; i++) begin
            send_tok(2'd0);
            dwell++;
            if (int'(bus.o_offset) != last_off) begin
                if (int'(bus.o_offset) != last_off + 1) adv_bad++;
                if (dwell != 64) dwell_bad++;
                dwell    = 0;
                last_off = int'(bus.o_offset);
            end
        end
        chk("t2_locked", bus.o_locked, 1);
        chk("t2_offset", bus.o_offset, 7);
        chk("t2_dwell", dwell_bad, 0);
        chk("t2_advance", adv_bad, 0);
        for (int j = 0; j < 3; j++) begin
            send_tok(2'd0);
            check_out("t2_blank");
        end
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 32; j++) begin
                send_data(8'(j * 37 + c * 11 + 5));
                check_out("t2_data");
            end
            for (int j = 0; j < 3; j++) begin
                send_tok(2'd0);
                check_out("t2_blank2");
            end
        end
        for (int k = 0; k < 4; k++) begin
            send_tok(2'(k));
            check_out("t3_ctrl");
        end
        for (int j = 0; j < 2; j++) begin
            send_tok(2'd0);
            if (j == 1) chk("t3_ctrl_last", bus.o_ctrl, 3);
            else check_out("t3_ctrl");
        end

        // False VERIFY: two tokens then data
        slip = 0;
        do_reset();
        seen_lock = 0;
        send_tok(2'd0);
        send_tok(2'd0);
        for (int j = 0; j < 3; j++) begin
            send_data(8'h10 + 8'(j));
            if (bus.o_locked) seen_lock++;
            if (j == 1) chk("t4_offset_hold", bus.o_offset, 0);
        end
        chk("t4_offset", bus.o_offset, 1);
        chk("t4_nolock", seen_lock, 0);

        // Loss of lock, then offset walk with wrap
        do_reset();
        for (int i = 0; i < 8; i++) send_tok(2'd0);
        chk("t5_locked", bus.o_locked, 1);
        err_cnt = 0; lock_bad = 0;
        for (int i = 8; i < 74; i++) begin
            if (i < 72) send_data(8'(i * 13));
            else send_word(10'h000, 11'h000);
            if (bus.o_err) err_cnt++;
            if (i < 73 && !bus.o_locked) lock_bad++;
        end
        chk("t5_err_pulse", bus.o_err, 1);
        chk("t5_unlocked", bus.o_locked, 0);
        chk("t5_offset_kept", bus.o_offset, 0);
        chk("t5_lock_held", lock_bad, 0);
        for (int m = 1; m <= 10; m++) begin
            for (int j = 0; j < 64; j++) begin
                send_word(10'h000, 11'h000);
                if (bus.o_err) err_cnt++;
                if (bus.o_locked) lock_bad++;
            end
            chk("t5_walk", bus.o_offset, 32'(m % 10));
        end
        chk("t5_err_count", err_cnt, 1);
        chk("t5_stay_unlocked", lock_bad, 0);

        // Reset mid-lock at slip 5
        slip = 5;
        do_reset();
        lock_with_tokens(600);
        chk("t6_locked", bus.o_locked, 1);
        chk("t6_offset", bus.o_offset, 5);
        rstn = 1'b0;
        send_tok(2'd1);
        rstn = 1'b1;
        chk("t6_rst_locked", bus.o_locked, 0);
        chk("t6_rst_offset", bus.o_offset, 0);
        chk("t6_rst_out", {bus.o_de, bus.o_ctrl, bus.o_data, bus.o_err}, 0);
        lock_with_tokens(600);
        chk("t6_relock", bus.o_locked, 1);
        chk("t6_reoffset", bus.o_offset, 5);
        send_data(8'hA5);
        send_tok(2'd0);
        send_tok(2'd0);
        check_out("t6_data");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
